// File: rtl/win_checker.sv
// Connect-N line detector: after each placement, walks outward from the new token
// in four directions one board cell per cycle and updates the sticky game-over flags.
module win_checker #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int CONNECT = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       start,
    input  logic [1:0] player,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic [5:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       game_won,
    output logic [1:0] winner,
    output logic       draw,
    output logic [5:0] move_count
);

    localparam logic signed [3:0] ROWS_S    = 4'(ROWS);
    localparam logic signed [3:0] COLS_S    = 4'(COLS);
    localparam logic        [5:0] COLS_U    = 6'(COLS);
    localparam logic        [5:0] CELLS_U   = 6'(ROWS * COLS);
    localparam logic        [2:0] CONNECT_U = 3'(CONNECT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN_POS = 2'd1,
        SCAN_NEG = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [2:0]  k_q, k_d;
    logic [2:0]  run_q, run_d;
    logic [1:0]  player_q, player_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic        win_q, win_d;
    logic [5:0]  move_count_q, move_count_d;
    logic        game_won_q, game_won_d;
    logic [1:0]  winner_q, winner_d;
    logic        draw_q, draw_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Candidate cell geometry for the current direction and step
    logic signed [3:0] dr, dc;
    logic signed [3:0] k_s, row_s, col_s;
    logic signed [3:0] off_r, off_c;
    logic signed [3:0] cand_row, cand_col;
    logic              scanning;
    logic              in_bounds;
    logic              match;
    logic [5:0]        cand_addr;

    always_comb begin
        dr = 4'sd0;
        dc = 4'sd0;
        case (dir_q)
            2'd0:    begin dr = 4'sd0; dc = 4'sd1;  end
            2'd1:    begin dr = 4'sd1; dc = 4'sd0;  end
            2'd2:    begin dr = 4'sd1; dc = 4'sd1;  end
            default: begin dr = 4'sd1; dc = -4'sd1; end
        endcase
    end

    always_comb begin
        k_s   = signed'({1'b0, k_q});
        row_s = signed'({1'b0, row_q});
        col_s = signed'({1'b0, col_q});
        off_r = dr * k_s;
        off_c = dc * k_s;
        if (state_q == SCAN_NEG) begin
            cand_row = row_s - off_r;
            cand_col = col_s - off_c;
        end else begin
            cand_row = row_s + off_r;
            cand_col = col_s + off_c;
        end
        scanning  = (state_q == SCAN_POS) || (state_q == SCAN_NEG);
        // Overflow past the far edge wraps negative, so this stays a correct bounds test
        in_bounds = (cand_row >= 4'sd0) && (cand_row < ROWS_S) &&
                    (cand_col >= 4'sd0) && (cand_col < COLS_S);
        cand_addr = {3'b000, cand_row[2:0]} * COLS_U + {3'b000, cand_col[2:0]};
        rd_addr   = (scanning && in_bounds) ? cand_addr : 6'd0;
        match     = scanning && in_bounds && (rd_data == player_q);
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        k_d          = k_q;
        run_d        = run_q;
        player_d     = player_q;
        row_d        = row_q;
        col_d        = col_q;
        win_d        = win_q;
        move_count_d = move_count_q;
        game_won_d   = game_won_q;
        winner_d     = winner_q;
        draw_d       = draw_q;

        case (state_q)
            IDLE: begin
                if (start && !game_won_q && !draw_q) begin
                    player_d     = player;
                    row_d        = row;
                    col_d        = col;
                    move_count_d = move_count_q + 6'd1;
                    dir_d        = 2'd0;
                    k_d          = 3'd1;
                    run_d        = 3'd1;
                    win_d        = 1'b0;
                    state_d      = SCAN_POS;
                end
            end
            SCAN_POS, SCAN_NEG: begin
                if (match) begin
                    run_d = run_q + 3'd1;
                    k_d   = k_q + 3'd1;
                    if (run_q + 3'd1 == CONNECT_U) begin
                        win_d   = 1'b1;
                        state_d = DONE;
                    end
                end else if (state_q == SCAN_POS) begin
                    k_d     = 3'd1;
                    state_d = SCAN_NEG;
                end else if (dir_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    // Run restarts at the placed token for the next direction
                    dir_d   = dir_q + 2'd1;
                    k_d     = 3'd1;
                    run_d   = 3'd1;
                    state_d = SCAN_POS;
                end
            end
            DONE: begin
                if (win_q) begin
                    game_won_d = 1'b1;
                    winner_d   = player_q;
                end else if (move_count_q == CELLS_U) begin
                    draw_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= IDLE;
            dir_q        <= 2'd0;
            k_q          <= 3'd0;
            run_q        <= 3'd0;
            player_q     <= 2'd0;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            win_q        <= 1'b0;
            move_count_q <= 6'd0;
            game_won_q   <= 1'b0;
            winner_q     <= 2'd0;
            draw_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            k_q          <= k_d;
            run_q        <= run_d;
            player_q     <= player_d;
            row_q        <= row_d;
            col_q        <= col_d;
            win_q        <= win_d;
            move_count_q <= move_count_d;
            game_won_q   <= game_won_d;
            winner_q     <= winner_d;
            draw_q       <= draw_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign game_won   = game_won_q;
    assign winner     = winner_q;
    assign draw       = draw_q;
    assign move_count = move_count_q;

endmodule

// File: tb/tb_win_checker.sv
// Self-checking bench for win_checker: line-walking board model, per-cycle read/flag checks.
module tb_win_checker;
    localparam int ROWS = 6, COLS = 7, CONNECT = 4, CELLS = ROWS * COLS;

    logic       Clock, Resetn, start;
    logic [1:0] player;
    logic [2:0] row, col;
    logic [5:0] rd_addr;
    logic [1:0] rd_data;
    logic       busy, done, game_won, draw;
    logic [1:0] winner;
    logic [5:0] move_count;

    logic [1:0] board [0:CELLS-1];

    int n_tests = 0, n_fail = 0;
    int exp_q[$];
    int m_seq[$];
    bit m_win;
    bit m_active = 0, m_won = 0, m_draw = 0;
    int m_winner = 0, m_count = 0;

    win_checker #(.ROWS(ROWS), .COLS(COLS), .CONNECT(CONNECT)) dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .player(player),
        .row(row), .col(col), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .game_won(game_won), .winner(winner),
        .draw(draw), .move_count(move_count)
    );

    assign rd_data = (int'(rd_addr) < CELLS) ? board[rd_addr] : 2'b00;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Walk outward from the token along each line, counting same-player cells
    task automatic model(input int r, input int c, input int p);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        m_seq.delete();
        m_win = 0;
        for (int d = 0; d < 4 && !m_win; d++) begin
            int run;
            run = 1;
            for (int s = 0; s < 2 && !m_win; s++) begin
                int sg;
                sg = (s == 0) ? 1 : -1;
                for (int k = 1; k < 8; k++) begin
                    int rr, cc;
                    bit inb;
                    rr  = r + sg * k * dr[d];
                    cc  = c + sg * k * dc[d];
                    inb = (rr >= 0) && (rr < ROWS) && (cc >= 0) && (cc < COLS);
                    m_seq.push_back(inb ? rr * COLS + cc : 0);
                    if (inb && int'(board[rr * COLS + cc]) == p) begin
                        run++;
                        if (run >= CONNECT) begin
                            m_win = 1;
                            break;
                        end
                    end else begin
                        break;
                    end
                end
            end
        end
    endtask

    always @(negedge Clock) begin
        if (Resetn) begin
            if (m_active) begin
                if (exp_q.size() > 0) begin
                    chk("scan_busy", busy, 1);
                    chk("scan_done", done, 0);
                    chk("rd_addr", rd_addr, exp_q.pop_front());
                end else begin
                    chk("done_pulse", done, 1);
                    chk("done_busy", busy, 1);
                    m_active = 0;
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
            end
            chk("game_won", game_won, m_won);
            chk("winner", winner, m_winner);
            chk("draw", draw, m_draw);
            chk("move_count", move_count, m_count);
        end
    end

    task automatic clear_board();
        for (int i = 0; i < CELLS; i++) board[i] = 2'b00;
    endtask

    task automatic do_reset();
        m_active = 0;
        exp_q.delete();
        start  = 0;
        Resetn = 0;
        #1;
        m_won = 0; m_draw = 0; m_winner = 0; m_count = 0;
        repeat (2) @(posedge Clock);
        #1 Resetn = 1;
    endtask

    task automatic do_move(input int r, input int c, input int p);
        bit acc;
        int n;
        model(r, c, p);
        acc    = !m_won && !m_draw;
        start  = 1;
        player = 2'(p);
        row    = 3'(r);
        col    = 3'(c);
        @(posedge Clock);
        #1 start = 0;
        $display("[TB] move r=%0d c=%0d p=%0d accepted=%0d win=%0d reads=%0d", r, c, p, acc, m_win, m_seq.size());
        if (acc) begin
            m_count++;
            exp_q    = m_seq;
            m_active = 1;
            n = 0;
            while (m_active && n < 40) begin
                @(posedge Clock);
                n++;
            end
            if (m_active) begin
                chk("done_timeout", 0, 1);
                m_active = 0;
            end
            #1;
            if (m_win) begin
                m_won = 1;
                m_winner = p;
            end else if (m_count == CELLS) begin
                m_draw = 1;
            end
        end
    endtask

    task automatic random_board();
        for (int i = 0; i < CELLS; i++) board[i] = 2'($urandom_range(0, 2));
    endtask

    initial begin
        int hseq[4] = '{39, 37, 36, 35};
        int vseq[5] = '{15, 0, 21, 28, 35};
        int wseq[8] = '{39, 37, 0, 31, 0, 30, 0, 32};
        int r, c, p;

        start = 0; player = 0; row = 0; col = 0;
        Resetn = 0;
        clear_board();
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_won", game_won, 0);
        chk("rst_draw", draw, 0);
        chk("rst_winner", winner, 0);
        chk("rst_count", move_count, 0);
        chk("rst_addr", rd_addr, 0);
        Resetn = 1;
        @(posedge Clock); #1;

        // Horizontal win on the bottom row, placed at the right end
        for (int i = 0; i < 4; i++) board[5 * COLS + i] = 2'b01;
        model(5, 3, 1);
        chk("h_len", m_seq.size(), 4);
        for (int i = 0; i < 4; i++) chk("h_seq", m_seq[i], hseq[i]);
        do_move(5, 3, 1);
        chk("h_won", game_won, 1);
        chk("h_winner", winner, 2'b01);
        do_move(5, 4, 1);
        chk("h_lock_busy", busy, 0);
        chk("h_lock_count", move_count, 1);
        do_reset();

        // Vertical win for P2 in column 0
        clear_board();
        for (int i = 2; i < 6; i++) board[i * COLS] = 2'b10;
        model(2, 0, 2);
        chk("v_len", m_seq.size(), 5);
        for (int i = 0; i < 5; i++) chk("v_seq", m_seq[i], vseq[i]);
        do_move(2, 0, 2);
        chk("v_winner", winner, 2'b10);
        do_reset();

        // Anti-diagonal completed on the negative side
        clear_board();
        board[5 * COLS + 0] = 2'b01;
        board[4 * COLS + 1] = 2'b01;
        board[3 * COLS + 2] = 2'b01;
        board[2 * COLS + 3] = 2'b01;
        model(4, 1, 1);
        chk("ad_len", m_seq.size(), 10);
        chk("ad_last", m_seq[9], 17);
        do_move(4, 1, 1);
        chk("ad_won", game_won, 1);
        chk("ad_winner", winner, 2'b01);
        do_reset();

        // Isolated token: all eight scan cycles
        clear_board();
        board[5 * COLS + 2] = 2'b10; board[5 * COLS + 4] = 2'b10;
        board[4 * COLS + 2] = 2'b10; board[4 * COLS + 3] = 2'b10;
        board[4 * COLS + 4] = 2'b10;
        model(5, 3, 1);
        chk("w_len", m_seq.size(), 8);
        for (int i = 0; i < 8; i++) chk("w_seq", m_seq[i], wseq[i]);
        do_move(5, 3, 1);
        chk("w_won", game_won, 0);
        chk("w_draw", draw, 0);
        chk("w_count", move_count, 1);

        // Reset dropped while the check sits in SCAN_NEG
        model(5, 3, 1);
        start = 1; player = 2'b01; row = 3'd5; col = 3'd3;
        @(posedge Clock);
        #1 start = 0;
        m_count++;
        exp_q = m_seq;
        m_active = 1;
        @(posedge Clock);
        #1;
        m_active = 0;
        exp_q.delete();
        Resetn = 0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_won", game_won, 0);
        chk("ar_count", move_count, 0);
        m_won = 0; m_draw = 0; m_winner = 0; m_count = 0;
        repeat (2) @(posedge Clock);
        #1 Resetn = 1;
        repeat (2) @(posedge Clock);
        #1;
        chk("ar_idle", busy, 0);

        // Random boards and moves, wins included; lock-out probed after each game end
        for (int t = 0; t < 70; t++) begin
            random_board();
            r = $urandom_range(0, ROWS - 1);
            c = $urandom_range(0, COLS - 1);
            p = $urandom_range(1, 2);
            do_move(r, c, p);
            if (m_won || m_draw) begin
                do_move(r, c, p);
                do_reset();
            end
        end

        // Draw: 42 accepted checks that never complete a line
        do_reset();
        for (int t = 0; t < CELLS; t++) begin
            bit found;
            found = 0;
            for (int a = 0; a < 20 && !found; a++) begin
                random_board();
                r = $urandom_range(0, ROWS - 1);
                c = $urandom_range(0, COLS - 1);
                p = $urandom_range(1, 2);
                model(r, c, p);
                found = !m_win;
            end
            if (!found) clear_board();
            do_move(r, c, p);
        end
        chk("dr_draw", draw, 1);
        chk("dr_won", game_won, 0);
        chk("dr_count", move_count, 42);
        do_move(0, 0, 1);
        chk("dr_lock_busy", busy, 0);
        chk("dr_lock_count", move_count, 42);
        @(posedge Clock); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
